serial_transmit: RTL and testbench
==================================

// Module: serial_transmit
// PURPOSE
//  Serial (UART-style) transmitter. The peer of the receive path.
//  - Accepts 8-bit characters over a load/ready handshake.
//  - Frames each as 10 bits: start 0, data LSB first, stop 1.
//  - Drives them onto the serial line at 1 bit per CLKS_PER_BIT clocks.
//  - One-entry holding register lets the next character queue during a frame,
//    so back-to-back frames go out with no idle gap.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit (matches 16x receive oversampling)
//  DATA_BITS     8   payload bits per frame; frame = DATA_BITS+2 bits
// PORTS
//  clk       in   1          system clock, single domain, all logic on rising edge
//  reset     in   1          synchronous, active-high
//  data_in   in   DATA_BITS  character to send; sampled only when load && ready
//  load      in   1          request strobe, qualified by ready
//  ready     out  1          holding register empty; may accept a load this cycle
//  busy      out  1          a frame is on the line (state != IDLE)
//  data_out  out  1          serial line; idles high
//  charSent  out  1          1-cycle pulse on the last clock of each stop bit
// BEHAVIOUR
//  Reset:
//  - data_out=1, ready=1, busy=0, charSent=0.
//  - state=IDLE; bit timer, bit counter and shifter cleared; holding marked empty.
//  - Reset mid-frame aborts it: line high after that edge, holding discarded,
//    no charSent.
//  FSM IDLE -> START -> DATA -> STOP -> (START | IDLE):
//  - IDLE: data_out=1. On load&&ready, data_in goes straight to the shifter
//    (bypassing holding), state=START, and data_out=0 from that edge.
//    ready stays 1.
//  - START: data_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//  - DATA: data_out=shifter[0]. Each bit lasts CLKS_PER_BIT cycles, then the
//    shifter shifts right. After bit DATA_BITS-1, go to STOP.
//  - STOP: data_out=1 for CLKS_PER_BIT cycles. On the last cycle charSent=1.
//    If holding is full, the shifter loads from holding, state=START, and
//    holding is freed (no idle cycle). Otherwise state=IDLE.
//  Handshake:
//  - load&&ready while busy writes holding; ready=0 from the next cycle.
//  - ready returns to 1 on the cycle after holding drains into the shifter.
//  - load with ready=0 is ignored: no state change, data dropped.
//  - No simultaneous load/drain conflict exists: drain needs holding full,
//    which forces ready=0.
//  Timing:
//  - Bit timer counts 0..CLKS_PER_BIT-1; the tick fires at CLKS_PER_BIT-1.
//  - Timer restarts at 0 on every state entry.
//  - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles. No cumulative drift.
//  - Bit counter width is clog2(DATA_BITS) and never wraps past DATA_BITS-1.
//  Outputs: all are registered; no combinational path from load to data_out.
// STRUCTURE
//  Shared include serial_defs.v holds:
//  - FSM state encodings (IDLE, START, DATA, STOP)
//  - START_BIT=1'b0, STOP_BIT=1'b1, FRAME_BITS=DATA_BITS+2
//  The receive path uses the same file.
//  One sub-module, bit_timer, owns the CLKS_PER_BIT counter.
//  - inputs: clk, reset, restart
//  - output: tick
//  The top level holds the FSM, bit counter, shifter and holding register.
// TESTING
//  1. Reset, then 40 idle cycles -> data_out=1, ready=1, busy=0, charSent never 1.
//  2. load 8'hA5 from idle -> line 0 for 16 clocks, then 1,0,1,0,0,1,0,1 at
//     16 clocks each, then 1 for 16; charSent on cycle 160; busy falls after it.
//  3. load 8'h55 then 8'h0F four cycles later -> ready falls; 8'h0F's start bit
//     immediately follows 8'h55's stop bit (0 gap); 2 charSent pulses 160 apart.
//  4. With holding full, load 8'hFF -> ignored. Only the two queued characters
//     appear on the line.
//  5. reset asserted mid-DATA of 8'h3C -> data_out=1 the next cycle, ready=1,
//     no charSent. A following load 8'h81 transmits cleanly.
//  6. Loopback into the receive path, CLKS_PER_BIT=16, sending 8'h00, 8'hFF,
//     8'h5A -> the receiver's 10-bit frames decode to the same bytes, each with
//     start=0 and stop=1.

Source files
------------

// File: rtl/serial_transmit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmit_pkg
// Description : Shared line-level definitions for the serial transmit and
//               receive paths: FSM encodings, framing levels, width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_transmit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_transmit_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmit_bit_timer
// Description : Bit-period counter, 0..CLKS_PER_BIT-1, ticking on the last
//               count. tick_next flags that the coming cycle is the tick.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_transmit_bit_timer
    import serial_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick,
    output logic tick_next
);

    localparam int             CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (restart || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick      = (count_q == LAST);
    assign tick_next = (count_d == LAST);

endmodule
`default_nettype wire

// File: rtl/serial_transmit.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmit
// Description : UART-style transmitter, start/LSB-first data/stop framing,
//               one-entry holding register for gapless back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_transmit
    import serial_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 busy,
    output logic                 data_out,
    output logic                 charSent
);

    localparam int                   BIT_CNT_W = cnt_width(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

    logic [1:0]           state_q,     state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shifter_q,   shifter_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 data_out_q,  data_out_d;
    logic                 ready_q,     ready_d;
    logic                 busy_q,      busy_d;
    logic                 char_sent_q, char_sent_d;

    logic w_accept;
    logic w_tick;
    logic w_tick_next;
    logic w_restart;

    assign w_accept  = load && ready_q;
    // Timer is held at zero while idle and re-zeroed on every state entry.
    assign w_restart = (state_q == ST_IDLE) || (state_d != state_q);

    serial_transmit_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (w_restart),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shifter_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            data_out_q  <= STOP_BIT;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            char_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shifter_q   <= shifter_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            data_out_q  <= data_out_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            char_sent_q <= char_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (w_accept && (state_q != ST_IDLE)) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    shifter_d = data_in;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    shifter_d = shifter_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    // A load landing on the final stop cycle with holding empty
                    // starts the next frame directly rather than being stranded.
                    if (hold_full_q) begin
                        shifter_d   = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = ST_START;
                    end else if (w_accept) begin
                        shifter_d   = data_in;
                        hold_full_d = 1'b0;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        ready_d     = !hold_full_d;
        char_sent_d = (state_q == ST_STOP) && w_tick_next;
        case (state_d)
            ST_START: data_out_d = START_BIT;
            ST_DATA:  data_out_d = shifter_d[0];
            default:  data_out_d = STOP_BIT;
        endcase
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign data_out = data_out_q;
    assign charSent = char_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_transmit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_transmit
// Description : Self-checking bench for serial_transmit; a line decoder pops
//               expected characters queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_transmit;

    localparam int CLKS      = 16;
    localparam int FRAME_CYC = 10 * CLKS;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       load    = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic       busy;
    logic       data_out;
    logic       charSent;

    serial_transmit #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .ready    (ready),
        .busy     (busy),
        .data_out (data_out),
        .charSent (charSent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Line decoder: one sample per clock at the falling edge.
    bit         in_frame = 1'b0;
    int         pos      = 0;
    int         gap      = 0;
    bit         stable   = 1'b1;
    logic [9:0] bits     = '0;
    exp_t       cur      = '0;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
            gap      = 0;
        end else begin
            if (charSent && !(in_frame && pos == FRAME_CYC - 1))
                check("char_sent_spurious", charSent, 1'b0);
            if (!in_frame) begin
                if (data_out === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    stable   = 1'b1;
                    bits     = '0;
                    if (exp_q.size() == 0) begin
                        check("frame_expected", 1, 0);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.b2b) check("back_to_back_gap", gap, 0);
                    end
                end else begin
                    gap++;
                end
            end
            if (in_frame) begin
                if (pos % CLKS == 0) bits[pos / CLKS] = data_out;
                else if (data_out !== bits[pos / CLKS]) stable = 1'b0;
                if (pos == FRAME_CYC - 1) begin
                    check("char_sent_at_stop_end", charSent, 1'b1);
                    check("bit_timing_stable", stable, 1'b1);
                    check("start_stop_bits", {bits[9], bits[0]}, 2'b10);
                    check("frame_data", bits[8:1], cur.data);
                    in_frame = 1'b0;
                    gap      = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit b2b);
        int guard = 0;
        while (ready !== 1'b1 && guard < 1000) begin
            step();
            guard++;
        end
        check("ready_before_load", ready, 1'b1);
        data_in = b;
        load    = 1'b1;
        exp_q.push_back('{data: b, b2b: b2b});
        step();
        load    = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic wait_char(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (charSent !== 1'b1 && n < 1000);
        check("char_sent_timeout", (n < 1000), 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || in_frame) && n < 5000) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 5000), 1'b1);
    endtask

    initial begin
        int  n;
        bit  idle_ok;

        // Reset and quiet line
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_data_out", data_out, 1'b1);
        check("reset_ready", ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_char_sent", charSent, 1'b0);
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (data_out !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || charSent !== 1'b0)
                idle_ok = 1'b0;
        end
        check("idle_40_cycles", idle_ok, 1'b1);

        // Single character from idle
        send(8'hA5, 1'b0);
        check("a5_start_line", data_out, 1'b0);
        check("a5_busy", busy, 1'b1);
        check("a5_ready_stays", ready, 1'b1);
        wait_char(n);
        check("a5_char_sent_cycle", n + 1, FRAME_CYC);
        check("a5_busy_at_char_sent", busy, 1'b1);
        step();
        check("a5_busy_falls", busy, 1'b0);
        check("a5_line_idle", data_out, 1'b1);
        wait_idle();

        // Queued second character, gapless
        send(8'h55, 1'b0);
        repeat (3) step();
        send(8'h0F, 1'b1);
        check("hold_ready_low", ready, 1'b0);
        wait_char(n);
        check("hold_ready_low_at_stop", ready, 1'b0);
        step();
        check("hold_ready_returns", ready, 1'b1);
        wait_char(n);
        check("char_sent_spacing", n + 1, FRAME_CYC);
        wait_idle();

        // Load while holding full is dropped
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        data_in = 8'hFF;
        load    = 1'b1;
        repeat (3) step();
        load    = 1'b0;
        data_in = 8'h00;
        check("ignored_load_ready", ready, 1'b0);
        wait_idle();

        // Reset mid-DATA aborts the frame
        send(8'h3C, 1'b0);
        repeat (60) step();
        reset = 1'b1;
        step();
        check("abort_line_high", data_out, 1'b1);
        check("abort_ready", ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_char_sent", charSent, 1'b0);
        reset = 1'b0;
        repeat (20) step();
        send(8'h81, 1'b0);
        wait_idle();

        // Loopback-style decode of a back-to-back burst
        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
        send(8'h5A, 1'b1);
        wait_idle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
